instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Program loader: the write-side counterpart of the byte-addressed instruction ROM.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit words, MSB first; byte at address A is bits [31:24], matching the ROM's read ordering.
- Issues single-cycle word writes into instruction memory starting at the boot vector.
- Holds the CPU in reset until the image is complete.

Parameters:
- A_WIDTH, 32, address width.
- D_WIDTH, 8, stream byte width.
- BASE_ADDR, 32'hBFC00000, first write address (boot vector).
- DEPTH_BYTES, 4096, instruction memory size in bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load.
- num_words  in  A_WIDTH  words in the image; sampled on start.
- in_valid  in  1  stream byte valid.
- in_data  in  D_WIDTH  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- mem_we  out  1  word write strobe, one cycle.
- mem_addr  out  A_WIDTH  byte address of the word (4-aligned).
- mem_wdata  out  32  assembled word.
- busy  out  1  load in progress.
- done  out  1  image fully written; sticky.
- err  out  1  load aborted; sticky.
- cpu_rst_n  out  1  CPU reset release; 1 only while done=1.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters and assembly register cleared. A partial word is discarded on reset.
- FSM states: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - If num_words*4 > DEPTH_BYTES (computed in A_WIDTH+2 bits, no wrap), go to ERROR.
  - Else if num_words == 0, go to DONE.
  - Else go to RECV; clear done and err; word_idx=0, byte_idx=0.
- start while busy is ignored.
- RECV:
  - in_ready=1; a byte transfers when in_valid & in_ready.
  - Byte b of the word (b=0..3) goes to shift[31-8b -: 8]; byte_idx increments mod 4.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_addr = BASE_ADDR + 4*word_idx, mem_wdata = assembled word.
  - Then word_idx++. If word_idx == num_words go to DONE, else go to RECV.
- Latency: 4th byte accepted on edge N; mem_we is high during cycle N+1. Peak throughput is 4 bytes per 5 cycles.
- busy=1 in RECV and WRITE.
- mem_addr and mem_wdata are held stable outside WRITE; they hold the last value.
- DONE: done=1, cpu_rst_n=1. Any bytes offered are not accepted (in_ready=0).
- ERROR: err=1, cpu_rst_n=0, in_ready=0.
- Address arithmetic is A_WIDTH bits; the range check guarantees no wrap above BASE_ADDR+DEPTH_BYTES-1.
- A byte presented in the same cycle start is accepted is not consumed (in_ready is still 0).

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Loader keeps an 8-bit XOR of all image bytes.
  - After the last WRITE it enters CHECK (in_ready=1) and accepts one trailing byte.
  - Match: go to DONE. Mismatch: go to ERROR.
  - cpu_rst_n stays 0 until CHECK passes.
- Not defined: no CHECK state and no trailing byte; the last WRITE goes straight to DONE.

Decomposition:
- Package instr_loader_pkg:
  - State enum loader_state_t.
  - Constants BOOT_VECTOR=32'hBFC00000 and IMEM_BYTES=4096, shared with the instruction memory's range declaration.
  - Bytes-per-word constant 4.
- One sub-module, instr_word_packer: byte shift register, byte_idx counter, word_ready flag. The top module keeps the FSM, word counter and address generation.

Test Plan:
- start, num_words=2, bytes 13 00 50 93 01 00 00 6F with no stalls -> writes 0x13005093 @0xBFC00000 and 0x0100006F @0xBFC00004; each mem_we one cycle after its 4th byte; done=1 and cpu_rst_n=1 after the 2nd write.
- Same image with in_valid toggled randomly, plus in_valid held during WRITE -> identical writes; no byte lost or duplicated; in_ready=0 in every WRITE cycle.
- num_words=1025 (4100 bytes > 4096) -> err=1 next cycle; no mem_we; in_ready stays 0. num_words=1024 -> last write @0xBFC00FFC, done=1.
- num_words=0 -> done=1 one cycle after start; no mem_we.
- rst_n asserted asynchronously after 2 bytes of word 1 -> all outputs 0 immediately. A fresh load then writes word 0 from only the new bytes.
- LOADER_CHECKSUM_EN, image 13 00 50 93: trailing 0xD0 -> done=1; trailing 0x00 -> err=1, cpu_rst_n=0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the program loader and the instruction memory.
// LOADER_CHECKSUM_EN adds the CHECK state used by the trailing-checksum option.
package instr_loader_pkg;

  localparam logic [31:0] BOOT_VECTOR    = 32'hBFC00000;
  localparam int unsigned IMEM_BYTES     = 4096;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = 2;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
`ifdef LOADER_CHECKSUM_EN
    ,
    CHECK
`endif
  } loader_state_t;

endpackage

// File: rtl/instr_word_packer.sv
// Packs stream bytes MSB first into one word; byte 0 of a word lands in the top byte.
module instr_word_packer
  import instr_loader_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear_i,
  input  logic                              push_i,
  input  logic [D_WIDTH-1:0]                byte_i,
  output logic [BYTES_PER_WORD*D_WIDTH-1:0] word_c,
  output logic                              word_ready_c
);

  localparam int unsigned WW = BYTES_PER_WORD * D_WIDTH;

  logic [WW-1:0]         shift_q, shift_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;

  // Current byte merged into the partial word, so a completed word is visible on its last byte.
  always_comb begin
    word_c = shift_q;
    for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
      if (byte_idx_q == BYTE_IDX_W'(b)) begin
        word_c[WW-1-D_WIDTH*b -: D_WIDTH] = byte_i;
      end
    end
  end

  assign word_ready_c = push_i && (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    if (clear_i) begin
      shift_d    = '0;
      byte_idx_d = '0;
    end else if (push_i) begin
      shift_d    = word_c;
      byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Program loader: streams an image into instruction memory and holds the CPU in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned         A_WIDTH     = 32,
  parameter int unsigned         D_WIDTH     = 8,
  parameter logic [A_WIDTH-1:0]  BASE_ADDR   = A_WIDTH'(BOOT_VECTOR),
  parameter int unsigned         DEPTH_BYTES = IMEM_BYTES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_WIDTH-1:0] num_words,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cpu_rst_n
);

  localparam int unsigned REQ_W = A_WIDTH + 2;

  loader_state_t state_q, state_d;

  logic [A_WIDTH-1:0] num_words_q, num_words_d;
  logic [A_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_we_q, mem_we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;

`ifdef LOADER_CHECKSUM_EN
  logic [D_WIDTH-1:0] csum_q, csum_d;
`endif

  logic                              fire_c;
  logic                              push_c;
  logic                              pack_clear_c;
  logic                              word_ready_c;
  logic [BYTES_PER_WORD*D_WIDTH-1:0] word_c;
  logic [REQ_W-1:0]                  bytes_req_c;
  logic                              too_big_c;

  assign fire_c      = in_valid && in_ready_q;
  assign push_c      = fire_c && (state_q == RECV);
  // Byte count is formed two bits wider so an oversized image cannot wrap past the check.
  assign bytes_req_c = {num_words, 2'b00};
  assign too_big_c   = bytes_req_c > REQ_W'(DEPTH_BYTES);

  instr_word_packer #(
    .D_WIDTH (D_WIDTH)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pack_clear_c),
    .push_i       (push_c),
    .byte_i       (in_data),
    .word_c       (word_c),
    .word_ready_c (word_ready_c)
  );

  // Next-state logic; registered outputs are decoded from the next state.
  always_comb begin
    state_d      = state_q;
    num_words_d  = num_words_q;
    word_idx_d   = word_idx_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pack_clear_c = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (too_big_c) begin
            state_d = ERROR;
          end else if (num_words == '0) begin
            state_d = DONE;
          end else begin
            state_d      = RECV;
            num_words_d  = num_words;
            word_idx_d   = '0;
            pack_clear_c = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_d       = '0;
`endif
          end
        end
      end
      RECV: begin
`ifdef LOADER_CHECKSUM_EN
        if (push_c) begin
          csum_d = csum_q ^ in_data;
        end
`endif
        if (word_ready_c) begin
          state_d     = WRITE;
          mem_addr_d  = BASE_ADDR + (word_idx_q << 2);
          mem_wdata_d = WORD_W'(word_c);
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + A_WIDTH'(1);
        if (word_idx_d == num_words_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (fire_c) begin
          state_d = (in_data == csum_q) ? DONE : ERROR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == RECV);
    busy_d      = (state_d == RECV) || (state_d == WRITE);
`ifdef LOADER_CHECKSUM_EN
    in_ready_d  = in_ready_d || (state_d == CHECK);
    busy_d      = busy_d || (state_d == CHECK);
`endif
    mem_we_d    = (state_d == WRITE);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERROR);
    cpu_rst_n_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_words_q <= '0;
      word_idx_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_words_q <= num_words_d;
      word_idx_q  <= word_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: image bytes in, expected word writes derived from the image.
// Honours LOADER_CHECKSUM_EN by appending the XOR trailer byte to every load.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num_words = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;

  instr_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_rst_n (cpu_rst_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stream image (plus optional trailer) and the expected write count of the current load.
  logic [7:0] img [0:4100];
  int exp_n = 0;

  // Monitor: every observed write must be the next image word at the next word address,
  // one cycle after its fourth byte was accepted.
  int cyc = 0, acc_cnt = 0, wr_cnt = 0, last4 = -10;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n || start) begin
      acc_cnt = 0;
      wr_cnt  = 0;
    end else begin
      if (mem_we) begin
        check("wr_expected", 32'(wr_cnt < exp_n), 32'd1);
        if (wr_cnt < exp_n) begin
          check("wr_addr", mem_addr, BASE + 32'(4 * wr_cnt));
          check("wr_data", mem_wdata, {img[4*wr_cnt], img[4*wr_cnt+1], img[4*wr_cnt+2], img[4*wr_cnt+3]});
        end
        check("wr_in_ready", 32'(in_ready), 32'd0);
        check("wr_latency", 32'(cyc), 32'(last4 + 1));
        wr_cnt++;
      end
      if (in_valid && in_ready && acc_cnt < 4 * exp_n) begin
        if (acc_cnt % 4 == 3) last4 = cyc;
        acc_cnt++;
      end
    end
  end

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) img[i] = 8'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after start.
  task automatic pulse_start(input int n);
    start     = 1'b1;
    num_words = 32'(n);
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    @(posedge clk); #1;
    start     = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic send_stream(input int total, input int stall_pct);
    int p = 0;
    int budget = 0;
    logic acc;
    while (p < total && budget < 8 * total + 100) begin
      in_valid = ($urandom_range(99) >= stall_pct);
      in_data  = img[p];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) p++;
      budget++;
    end
    in_valid = 1'b0;
    check("stream_bytes_sent", 32'(p), 32'(total));
  endtask

  task automatic wait_end();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || err) break;
    end
  endtask

  task automatic run_load(input int n, input int stall_pct, input bit exp_ok);
    int total;
    logic [7:0] cs;
    total = 4 * n;
    exp_n = n;
`ifdef LOADER_CHECKSUM_EN
    cs = 8'h00;
    for (int i = 0; i < total; i++) cs = cs ^ img[i];
    if (!exp_ok) cs = (cs == 8'h00) ? 8'h01 : 8'h00;
    img[total] = cs;
    total++;
`else
    cs = 8'h00;
`endif
    pulse_start(n);
    #2;
    check("load_busy", 32'(busy), 32'd1);
    check("load_in_ready", 32'(in_ready), 32'd1);
    send_stream(total, stall_pct);
    wait_end();
    check("load_done", 32'(done), 32'(exp_ok));
    check("load_err", 32'(err), 32'(!exp_ok));
    check("load_cpu_rst_n", 32'(cpu_rst_n), 32'(exp_ok));
    check("load_busy_end", 32'(busy), 32'd0);
    check("load_writes", 32'(wr_cnt), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed two-word image, no stalls, then bytes offered while done.
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h50; img[3] = 8'h93;
    img[4] = 8'h01; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h6F;
    run_load(2, 0, 1'b1);
    check("fixed_last_addr", mem_addr, 32'hBFC00004);
    check("fixed_last_data", mem_wdata, 32'h0100006F);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) begin
      @(negedge clk);
      check("done_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Same image with random valid gaps.
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h50; img[3] = 8'h93;
    img[4] = 8'h01; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h6F;
    run_load(2, 40, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(4 * n);
      run_load(n, $urandom_range(0, 60), 1'b1);
    end

    // Oversized image is rejected without any write.
    exp_n = 0;
    pulse_start(1025);
    #2;
    check("big_err", 32'(err), 32'd1);
    check("big_done", 32'(done), 32'd0);
    check("big_busy", 32'(busy), 32'd0);
    check("big_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("big_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("big_writes", 32'(wr_cnt), 32'd0);

    // Empty image completes immediately.
    exp_n = 0;
    pulse_start(0);
    #2;
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err), 32'd0);
    check("zero_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("zero_writes", 32'(wr_cnt), 32'd0);

    // Largest image that fits.
    fill_random(4096);
    run_load(1024, 0, 1'b1);
    check("full_last_addr", mem_addr, 32'hBFC00FFC);

    // Asynchronous reset in the middle of the second word.
    fill_random(8);
    exp_n = 2;
    pulse_start(2);
    send_stream(6, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random(4);
    run_load(1, 30, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h50; img[3] = 8'h93;
    run_load(1, 0, 1'b1);
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h50; img[3] = 8'h93;
    run_load(1, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
